// File: rtl/multi_channel_data_sync_pkg.sv
// Shared definitions for the multi-channel data synchroniser:
// enable-event mode encodings and channel-index width helper.
package multi_channel_data_sync_pkg;

  typedef enum int {
    MODE_LEVEL  = 0,
    MODE_TOGGLE = 1
  } sync_mode_e;

  // max(1, clog2(num_ch)): a single channel still needs a 1-bit index
  function automatic int calc_ch_w(input int num_ch);
    int w;
    w = 1;
    while ((1 << w) < num_ch) w++;
    return w;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// Single-channel enable synchroniser with edge detect, capture strobe
// and hold register for the channel's data bus.
module data_sync_ch
  import multi_channel_data_sync_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_STAGES  = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_enable,
  input  logic [BUS_WIDTH-1:0] i_data,
  output logic                 o_event,
  output logic                 o_pulse,
  output logic [BUS_WIDTH-1:0] o_hold
);

  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_q;
  logic                  r_pulse;
  logic [BUS_WIDTH-1:0]  r_hold;
  logic                  w_last;

  assign w_last  = r_sync[NUM_STAGES-1];
  // Toggle handshake fires on either edge of the synced enable
  assign o_event = (TOGGLE_MODE == int'(MODE_TOGGLE)) ? (w_last ^ r_q)
                                                      : (w_last & ~r_q);
  assign o_pulse = r_pulse;
  assign o_hold  = r_hold;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync  <= '0;
      r_q     <= 1'b0;
      r_pulse <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_sync  <= {r_sync[NUM_STAGES-2:0], i_enable};
      r_q     <= w_last;
      r_pulse <= o_event;
      if (o_event) r_hold <= i_data;
    end
  end

endmodule

// File: rtl/multi_channel_data_sync.sv
// Multi-channel CDC data synchroniser: per-channel capture, pending/overrun
// tracking and a round-robin arbiter feeding one valid/ready output register.
module multi_channel_data_sync
  import multi_channel_data_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_STAGES  = 2,
  parameter int TOGGLE_MODE = 0,
  parameter int CH_W        = calc_ch_w(NUM_CH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic                        out_ready,
  input  logic                        ovr_clr,
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           overrun
);

  logic [NUM_CH-1:0]    w_event;
  logic [BUS_WIDTH-1:0] w_hold [NUM_CH];

  logic [NUM_CH-1:0]    r_pend;
  logic [NUM_CH-1:0]    r_ovr;
  logic [CH_W-1:0]      r_rr_ptr;
  logic                 r_valid;
  logic [BUS_WIDTH-1:0] r_bus;
  logic [CH_W-1:0]      r_ch;

  logic                 w_free;
  logic                 w_grant;
  logic [CH_W-1:0]      w_gidx;
  logic [CH_W-1:0]      w_gnext;
  logic [NUM_CH-1:0]    w_gmask;
  logic [NUM_CH-1:0]    w_new_ovr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      data_sync_ch #(
        .BUS_WIDTH   (BUS_WIDTH),
        .NUM_STAGES  (NUM_STAGES),
        .TOGGLE_MODE (TOGGLE_MODE)
      ) u_ch (
        .CLK      (CLK),
        .RST      (RST),
        .i_enable (bus_enable[gi]),
        .i_data   (unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH]),
        .o_event  (w_event[gi]),
        .o_pulse  (enable_pulse[gi]),
        .o_hold   (w_hold[gi])
      );
    end
  endgenerate

  assign w_free = !r_valid || out_ready;

  // First pending channel at or after the round-robin pointer
  always_comb begin : p_arb
    int v_idx;
    v_idx   = 0;
    w_grant = 1'b0;
    w_gidx  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      v_idx = int'(r_rr_ptr) + off;
      if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
      if (w_free && !w_grant && r_pend[v_idx]) begin
        w_grant = 1'b1;
        w_gidx  = CH_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_gnext = (int'(w_gidx) == NUM_CH - 1) ? '0 : w_gidx + 1'b1;
    w_gmask = w_grant ? (NUM_CH'(1) << w_gidx) : '0;
    // Granting a channel this edge frees its slot, so a same-edge event is not an overrun
    w_new_ovr = w_event & r_pend & ~w_gmask;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend   <= '0;
      r_ovr    <= '0;
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_bus    <= '0;
      r_ch     <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gmask) | w_event;
      r_ovr  <= w_new_ovr | (r_ovr & {NUM_CH{~ovr_clr}});
      if (w_grant) begin
        r_valid  <= 1'b1;
        r_bus    <= w_hold[w_gidx];
        r_ch     <= w_gidx;
        r_rr_ptr <= w_gnext;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sync_bus   = r_bus;
  assign sync_ch    = r_ch;
  assign sync_valid = r_valid;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_multi_channel_data_sync.sv
// Scoreboard bench: level-mode and toggle-mode instances share stimulus and are
// checked against a per-edge behavioural model built from sample history.
module tb_multi_channel_data_sync;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NS = 2;
  localparam int CW = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N*W-1:0] unsync_bus;
  logic [N-1:0]   bus_enable;
  logic           out_ready;
  logic           ovr_clr;

  logic [W-1:0]  bus_l, bus_t;
  logic [CW-1:0] ch_l, ch_t;
  logic          v_l, v_t;
  logic [N-1:0]  p_l, p_t, o_l, o_t;

  always #5 CLK = ~CLK;

  multi_channel_data_sync #(.NUM_CH(N), .BUS_WIDTH(W), .NUM_STAGES(NS), .TOGGLE_MODE(0)) u_lvl (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .out_ready(out_ready), .ovr_clr(ovr_clr), .sync_bus(bus_l), .sync_ch(ch_l),
    .sync_valid(v_l), .enable_pulse(p_l), .overrun(o_l));

  multi_channel_data_sync #(.NUM_CH(N), .BUS_WIDTH(W), .NUM_STAGES(NS), .TOGGLE_MODE(1)) u_tgl (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .out_ready(out_ready), .ovr_clr(ovr_clr), .sync_bus(bus_t), .sync_ch(ch_t),
    .sync_valid(v_t), .enable_pulse(p_t), .overrun(o_t));

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  d;
  } word_t;

  word_t q_l[$];
  word_t q_t[$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // m_smp[m][i][j]: enable value sampled j+1 edges ago (history since reset)
  bit [NS:0]  m_smp  [2][N];
  bit [W-1:0] m_hold [2][N];
  bit [N-1:0] m_pend [2];
  bit [N-1:0] m_pulse[2];
  bit [N-1:0] m_ovr  [2];
  bit         m_v    [2];
  bit [W-1:0] m_bus  [2];
  int         m_ch   [2];
  int         m_ptr  [2];

  task automatic model_step(input int m);
    bit [N-1:0] ev, old_pend;
    bit a, b, free, newo;
    int g, idx;
    word_t w;
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        m_smp[m][i]  = '0;
        m_hold[m][i] = '0;
      end
      m_pend[m] = '0; m_pulse[m] = '0; m_ovr[m] = '0;
      m_v[m] = 1'b0; m_bus[m] = '0; m_ch[m] = 0; m_ptr[m] = 0;
      if (m == 0) q_l.delete(); else q_t.delete();
      return;
    end
    for (int i = 0; i < N; i++) begin
      a = m_smp[m][i][NS-1];
      b = m_smp[m][i][NS];
      ev[i] = (m == 1) ? (a ^ b) : (a & !b);
    end
    free = !m_v[m] || out_ready;
    g = -1;
    if (free)
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr[m] + off) % N;
        if (g < 0 && m_pend[m][idx]) g = idx;
      end
    old_pend = m_pend[m];
    if (g >= 0) begin
      m_v[m]   = 1'b1;
      m_bus[m] = m_hold[m][g];
      m_ch[m]  = g;
      w.ch = CW'(g);
      w.d  = m_hold[m][g];
      if (m == 0) q_l.push_back(w); else q_t.push_back(w);
      m_pend[m][g] = 1'b0;
      m_ptr[m] = (g + 1) % N;
    end else if (free) begin
      m_v[m] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      m_pulse[m][i] = ev[i];
      newo = ev[i] && old_pend[i] && (i != g);
      if (ev[i]) begin
        m_hold[m][i] = unsync_bus[i*W +: W];
        m_pend[m][i] = 1'b1;
      end
      m_ovr[m][i] = newo || (m_ovr[m][i] && !ovr_clr);
      m_smp[m][i] = {m_smp[m][i][NS-1:0], bus_enable[i]};
    end
  endtask

  always @(posedge CLK) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h expected=%0h t=%0t", name, m, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int m, input logic v, input logic [W-1:0] b,
                           input logic [CW-1:0] c, input logic [N-1:0] p, input logic [N-1:0] o);
    word_t w;
    int sz;
    chk("sync_valid", m, 32'(v), 32'(m_v[m]));
    chk("enable_pulse", m, 32'(p), 32'(m_pulse[m]));
    chk("overrun", m, 32'(o), 32'(m_ovr[m]));
    if (v && m_v[m]) begin
      chk("sync_bus", m, 32'(b), 32'(m_bus[m]));
      chk("sync_ch", m, 32'(c), 32'(m_ch[m]));
    end
    if (v && out_ready && !RST) begin
      sz = (m == 0) ? q_l.size() : q_t.size();
      checks++;
      if (sz == 0) begin
        failures++;
        $display("FAIL sb_unexpected dut%0d got=%0h/%0d expected=none t=%0t", m, b, c, $time);
      end else begin
        w = (m == 0) ? q_l.pop_front() : q_t.pop_front();
        if ({c, b} !== {w.ch, w.d}) begin
          failures++;
          $display("FAIL sb_word dut%0d got=%0h/%0d expected=%0h/%0d t=%0t", m, b, c, w.d, w.ch, $time);
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      check_dut(0, v_l, bus_l, ch_l, p_l, o_l);
      check_dut(1, v_t, bus_t, ch_t, p_t, o_t);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic pulse_ch(input int ch, input logic [W-1:0] d, input int gap);
    unsync_bus[ch*W +: W] = d;
    bus_enable[ch] = 1'b1;
    tick(1);
    bus_enable[ch] = 1'b0;
    tick(gap);
  endtask

  initial begin
    RST = 1'b1; unsync_bus = '0; bus_enable = '0; out_ready = 1'b1; ovr_clr = 1'b0;
    tick(3);
    RST = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // single word on ch1
    pulse_ch(1, 8'hA3, 7);

    // simultaneous events on ch0/ch2/ch3, twice
    for (int r = 0; r < 2; r++) begin
      unsync_bus[0*W +: W] = 8'h11;
      unsync_bus[2*W +: W] = 8'h22;
      unsync_bus[3*W +: W] = 8'h33;
      bus_enable = 4'b1101;
      tick(1);
      bus_enable = '0;
      tick(8);
    end

    // backpressure
    out_ready = 1'b0;
    pulse_ch(0, 8'h55, 4);
    pulse_ch(1, 8'h66, 6);
    out_ready = 1'b1;
    tick(6);

    // overrun on ch2 then clear
    out_ready = 1'b0;
    pulse_ch(2, 8'h77, 5);
    pulse_ch(2, 8'h88, 5);
    pulse_ch(2, 8'h99, 5);
    out_ready = 1'b1;
    tick(5);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    tick(3);

    // stuck enable with changing bus
    unsync_bus[0*W +: W] = 8'h99;
    bus_enable[0] = 1'b1;
    tick(4);
    unsync_bus[0*W +: W] = 8'hAA;
    tick(3);
    unsync_bus[0*W +: W] = 8'hBB;
    tick(3);
    bus_enable[0] = 1'b0;
    tick(6);

    // toggle handshake on ch3
    unsync_bus[3*W +: W] = 8'h44;
    bus_enable[3] = 1'b1;
    tick(5);
    unsync_bus[3*W +: W] = 8'h45;
    bus_enable[3] = 1'b0;
    tick(6);

    // reset with words pending, enable on ch2 high across release
    out_ready = 1'b0;
    unsync_bus[0*W +: W] = 8'h5A;
    unsync_bus[1*W +: W] = 8'hA5;
    bus_enable[1:0] = 2'b11;
    tick(1);
    bus_enable[1:0] = 2'b00;
    tick(4);
    RST = 1'b1;
    unsync_bus[2*W +: W] = 8'hC7;
    bus_enable[2] = 1'b1;
    tick(2);
    RST = 1'b0;
    out_ready = 1'b1;
    tick(8);
    bus_enable[2] = 1'b0;
    tick(6);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(15) == 0) bus_enable[i] = ~bus_enable[i];
      unsync_bus = $urandom();
      out_ready  = ($urandom_range(3) != 0);
      ovr_clr    = ($urandom_range(31) == 0);
      RST        = ($urandom_range(499) == 0);
      tick(1);
    end

    RST = 1'b0; bus_enable = '0; out_ready = 1'b1; ovr_clr = 1'b0;
    tick(20);
    chk("drain_lvl", 0, 32'(q_l.size()), 32'd0);
    chk("drain_tgl", 1, 32'(q_t.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
